// File: rtl/player_motion_if.sv
// Keycode inputs and per-player display outputs between the SoC side
// and the fighter motion controller.
interface player_motion_if #(
  parameter int NUM_PLAYERS = 2
);
  logic [7:0]               keycode_0;
  logic [7:0]               keycode_1;
  logic [7:0]               keycode_2;
  logic [7:0]               keycode_3;
  logic [10*NUM_PLAYERS-1:0] pos_x;
  logic [10*NUM_PLAYERS-1:0] pos_y;
  logic [2*NUM_PLAYERS-1:0]  state;
  logic [NUM_PLAYERS-1:0]    facing;
  logic [NUM_PLAYERS-1:0]    attack_active;
  logic                      frame_tick;

  modport master (
    output keycode_0, keycode_1,
    output keycode_2, keycode_3,
    input  pos_x, pos_y, state,
    input  facing, attack_active,
    input  frame_tick
  );

  modport slave (
    input  keycode_0, keycode_1,
    input  keycode_2, keycode_3,
    output pos_x, pos_y, state,
    output facing, attack_active,
    output frame_tick
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// Per-frame walk/jump/attack controller for up to four fighters,
// stepped once per VGA vsync rising edge.
module player_motion_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter logic [32*NUM_PLAYERS-1:0] KEY_MAP =
    {8'h10, 8'h52, 8'h4F, 8'h50,
     8'h09, 8'h1A, 8'h07, 8'h04},
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 575,
  parameter int GROUND_Y      = 352,
  parameter int SPACING       = 256,
  parameter int PLAYER_W      = 64,
  parameter int WALK_STEP     = 2,
  parameter int JUMP_VEL      = 12,
  parameter int GRAVITY       = 1,
  parameter int ATTACK_FRAMES = 12
) (
  input logic Clk,
  input logic Reset_n,
  input logic vs,
  player_motion_if.slave io
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    AIR    = 2'd2,
    ATTACK = 2'd3
  } st_e;

  localparam int NP = NUM_PLAYERS;

  localparam logic signed [11:0] XMIN_S = 12'(X_MIN);
  localparam logic signed [11:0] XMAX_S = 12'(X_MAX);
  localparam logic signed [11:0] STEP_S = 12'(WALK_STEP);
  localparam logic signed [11:0] PW_S   = 12'(PLAYER_W);
  localparam logic signed [10:0] GY_S   = 11'(GROUND_Y);
  localparam logic [9:0]         GY     = 10'(GROUND_Y);
  localparam logic signed [7:0]  JV     = 8'(JUMP_VEL);
  localparam logic signed [7:0]  GRAV   = 8'(GRAVITY);
  localparam logic [7:0]         AF     = 8'(ATTACK_FRAMES);

  logic s1, s2, s3;
  logic tick;

  st_e                st_q   [NP];
  st_e                st_d   [NP];
  logic [9:0]         x_q    [NP];
  logic [9:0]         x_d    [NP];
  logic [9:0]         y_q    [NP];
  logic [9:0]         y_d    [NP];
  logic signed [7:0]  vel_q  [NP];
  logic signed [7:0]  vel_d  [NP];
  logic [7:0]         cnt_q  [NP];
  logic [7:0]         cnt_d  [NP];
  logic               held_q [NP];
  logic               held_d [NP];
  logic               face_q [NP];
  logic               face_d [NP];

  function automatic logic hit(
    input logic [7:0] c,
    input logic [7:0] k0,
    input logic [7:0] k1,
    input logic [7:0] k2,
    input logic [7:0] k3
  );
    return (c != 8'h00) &&
      (c == k0 || c == k1 ||
       c == k2 || c == k3);
  endfunction

  assign tick = s2 & ~s3;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= vs;
      s2 <= s1;
      s3 <= s2;
    end
  end

  logic              k_l, k_r, k_j, k_a;
  logic              mv, blk;
  logic signed [11:0] cand, diff;
  logic signed [10:0] yn;

  always_comb begin
    k_l  = 1'b0;
    k_r  = 1'b0;
    k_j  = 1'b0;
    k_a  = 1'b0;
    mv   = 1'b0;
    blk  = 1'b0;
    cand = '0;
    diff = '0;
    yn   = '0;
    for (int i = 0; i < NP; i++) begin
      st_d[i]   = st_q[i];
      x_d[i]    = x_q[i];
      y_d[i]    = y_q[i];
      vel_d[i]  = vel_q[i];
      cnt_d[i]  = cnt_q[i];
      face_d[i] = face_q[i];

      k_l = hit(KEY_MAP[32*i +: 8],
                io.keycode_0, io.keycode_1,
                io.keycode_2, io.keycode_3);
      k_r = hit(KEY_MAP[32*i+8 +: 8],
                io.keycode_0, io.keycode_1,
                io.keycode_2, io.keycode_3);
      k_j = hit(KEY_MAP[32*i+16 +: 8],
                io.keycode_0, io.keycode_1,
                io.keycode_2, io.keycode_3);
      k_a = hit(KEY_MAP[32*i+24 +: 8],
                io.keycode_0, io.keycode_1,
                io.keycode_2, io.keycode_3);

      held_d[i] = k_a & held_q[i];
      mv = k_l ^ k_r;

      cand = k_r ? $signed({2'b00, x_q[i]}) + STEP_S
                 : $signed({2'b00, x_q[i]}) - STEP_S;
      if (cand < XMIN_S) cand = XMIN_S;
      if (cand > XMAX_S) cand = XMAX_S;

      // Blocking uses last frame's positions so players never need arbitration
      blk = 1'b0;
      for (int j = 0; j < NP; j++) begin
        diff = cand - $signed({2'b00, x_q[j]});
        if (diff < 0) diff = -diff;
        if (j != i && diff < PW_S) blk = 1'b1;
      end

      yn = $signed({1'b0, y_q[i]}) - 11'(vel_q[i]);

      unique case (st_q[i])
        IDLE, WALK: begin
          if (k_a && !held_q[i]) begin
            st_d[i]   = ATTACK;
            cnt_d[i]  = AF;
            held_d[i] = 1'b1;
          end else if (k_j) begin
            st_d[i]  = AIR;
            vel_d[i] = JV;
          end else if (mv) begin
            st_d[i]   = WALK;
            face_d[i] = k_r;
            if (!blk) x_d[i] = cand[9:0];
          end else begin
            st_d[i] = IDLE;
          end
        end
        AIR: begin
          vel_d[i] = vel_q[i] - GRAV;
          if (yn < 0) begin
            y_d[i] = '0;
          end else if (yn >= GY_S) begin
            y_d[i]  = GY;
            st_d[i] = IDLE;
          end else begin
            y_d[i] = yn[9:0];
          end
          if (mv) begin
            face_d[i] = k_r;
            if (!blk) x_d[i] = cand[9:0];
          end
        end
        ATTACK: begin
          cnt_d[i] = cnt_q[i] - 8'd1;
          if (cnt_d[i] == 8'd0) st_d[i] = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NP; i++) begin
        st_q[i]   <= IDLE;
        x_q[i]    <= 10'(X_MIN + i * SPACING);
        y_q[i]    <= GY;
        vel_q[i]  <= '0;
        cnt_q[i]  <= '0;
        held_q[i] <= 1'b0;
        face_q[i] <= (i == 0);
      end
    end else if (tick) begin
      for (int i = 0; i < NP; i++) begin
        st_q[i]   <= st_d[i];
        x_q[i]    <= x_d[i];
        y_q[i]    <= y_d[i];
        vel_q[i]  <= vel_d[i];
        cnt_q[i]  <= cnt_d[i];
        held_q[i] <= held_d[i];
        face_q[i] <= face_d[i];
      end
    end
  end

  always_comb begin
    io.pos_x         = '0;
    io.pos_y         = '0;
    io.state         = '0;
    io.facing        = '0;
    io.attack_active = '0;
    io.frame_tick    = tick;
    for (int i = 0; i < NP; i++) begin
      io.pos_x[10*i +: 10]   = x_q[i];
      io.pos_y[10*i +: 10]   = y_q[i];
      io.state[2*i +: 2]     = st_q[i];
      io.facing[i]           = face_q[i];
      io.attack_active[i]    = (st_q[i] == ATTACK);
    end
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed checks of the two-player motion controller: reset, strobe
// timing, walking/blocking, jump arc, async reset, attack timing.
module tb_player_motion_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  player_motion_if #(.NUM_PLAYERS(2)) io ();

  player_motion_ctrl dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .vs      (vs),
    .io      (io.slave)
  );

  always #10 clk = ~clk;

  function automatic int px(input int i);
    return (i == 0) ? int'(io.pos_x[9:0]) : int'(io.pos_x[19:10]);
  endfunction

  function automatic int py(input int i);
    return (i == 0) ? int'(io.pos_y[9:0]) : int'(io.pos_y[19:10]);
  endfunction

  function automatic int st(input int i);
    return (i == 0) ? int'(io.state[1:0]) : int'(io.state[3:2]);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic keys(input logic [7:0] a, input logic [7:0] b);
    io.keycode_0 = a;
    io.keycode_1 = b;
    io.keycode_2 = 8'h00;
    io.keycode_3 = 8'h00;
  endtask

  task automatic frame();
    @(negedge clk) vs = 1'b1;
    repeat (4) @(negedge clk);
    vs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  int jump_y [25] = '{340, 329, 319, 310, 302, 295, 289, 284, 280,
                      277, 275, 274, 274, 275, 277, 280, 284, 289,
                      295, 302, 310, 319, 329, 340, 352};

  initial begin
    int ticks;
    int act;
    keys(8'h00, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_x0", px(0), 0);
    chk("rst_x1", px(1), 256);
    chk("rst_y0", py(0), 352);
    chk("rst_y1", py(1), 352);
    chk("rst_state", int'(io.state), 0);
    chk("rst_facing", int'(io.facing), 1);
    chk("rst_attack", int'(io.attack_active), 0);

    ticks = 0;
    repeat (5) begin
      @(negedge clk);
      if (io.frame_tick) ticks++;
    end
    chk("no_tick_idle", ticks, 0);

    // Strobe latency: vs rises before edge 1, tick after edge 2, X after edge 3
    keys(8'h07, 8'h4F);
    @(negedge clk) vs = 1'b1;
    @(negedge clk);
    chk("tick_e1", int'(io.frame_tick), 0);
    @(negedge clk);
    chk("tick_e2", int'(io.frame_tick), 1);
    chk("x0_e2", px(0), 0);
    @(negedge clk);
    chk("tick_e3", int'(io.frame_tick), 0);
    chk("x0_e3", px(0), 2);
    chk("x1_e3", px(1), 258);
    chk("st0_e3", st(0), 1);
    repeat (2) @(negedge clk);
    vs = 1'b0;
    repeat (3) @(negedge clk);

    repeat (399) frame();
    chk("walk_x1_clamp", px(1), 575);
    chk("walk_x0_block", px(0), 510);
    chk("walk_st0", st(0), 1);
    chk("walk_facing", int'(io.facing), 3);

    keys(8'h1A, 8'h00);
    frame();
    chk("jump_start_y", py(0), 352);
    chk("jump_start_st", st(0), 2);
    keys(8'h00, 8'h00);
    for (int k = 0; k < 25; k++) begin
      frame();
      chk($sformatf("jump_y%0d", k + 1), py(0), jump_y[k]);
      if (k == 23) chk("jump_st_air", st(0), 2);
    end
    chk("jump_land_st", st(0), 0);
    chk("jump_x0", px(0), 510);

    keys(8'h1A, 8'h00);
    frame();
    keys(8'h00, 8'h00);
    repeat (5) frame();
    chk("midjump_y", py(0), 302);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("arst_x0", px(0), 0);
    chk("arst_x1", px(1), 256);
    chk("arst_y0", py(0), 352);
    chk("arst_state", int'(io.state), 0);
    chk("arst_facing", int'(io.facing), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frame();
    chk("post_rst_y0", py(0), 352);
    chk("post_rst_st0", st(0), 0);

    keys(8'h50, 8'h00);
    frame();
    chk("left_x1", px(1), 254);
    chk("left_face1", int'(io.facing[1]), 0);
    chk("left_st1", st(1), 1);
    repeat (99) frame();
    chk("left_x1_block", px(1), 64);
    chk("left_x0", px(0), 0);

    keys(8'h04, 8'h07);
    frame();
    chk("lr_x0", px(0), 0);
    chk("lr_face0", int'(io.facing[0]), 1);
    chk("lr_st0", st(0), 0);
    keys(8'h04, 8'h00);
    frame();
    chk("xmin_x0", px(0), 0);
    chk("xmin_face0", int'(io.facing[0]), 0);
    chk("xmin_st0", st(0), 1);

    keys(8'h09, 8'h00);
    act = 0;
    for (int f = 0; f < 40; f++) begin
      frame();
      if (io.attack_active[0]) act++;
      if (f == 0) chk("atk_enter", st(0), 3);
    end
    chk("atk_frames", act, 12);
    chk("atk_no_retrig", st(0), 0);
    chk("atk_flag_off", int'(io.attack_active), 0);
    keys(8'h00, 8'h00);
    frame();
    keys(8'h09, 8'h00);
    frame();
    chk("atk_repress", st(0), 3);
    chk("atk_repress_flag", int'(io.attack_active[0]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
